// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI slave front end and its wrapper:
//   - default frame / read-word widths
//   - opcode values carried in frame bits [9:8]
//   - FSM state encoding
// ---------------------------------------------------------------------------
package spi_pkg;

  localparam int SPI_INPUT_SIZE = 10;
  localparam int SPI_WORD_SIZE  = 8;

  // Opcodes in rx_data[9:8]. The front end passes them through untouched;
  // only bit 9 (read vs write) influences its own control path.
  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

endpackage

// File: rtl/spi_slave_frontend_if.sv
// ---------------------------------------------------------------------------
// spi_slave_frontend_if
// Serial pins plus the RAM-side parallel handshake of the SPI front end.
//   SS_n, MOSI, MISO   : SPI pins (slave select active low)
//   rx_data, rx_valid  : assembled frame and its one-cycle strobe
//   tx_data, tx_valid  : read data returned by the RAM
// Modports:
//   slave  : the front end's view
//   master : the SPI master / RAM model view
// ---------------------------------------------------------------------------
interface spi_slave_frontend_if
  import spi_pkg::*;
#(
  parameter int INPUT_SIZE = SPI_INPUT_SIZE,
  parameter int WORD_SIZE  = SPI_WORD_SIZE
);

  logic                  SS_n;
  logic                  MOSI;
  logic                  MISO;
  logic [INPUT_SIZE-1:0] rx_data;
  logic                  rx_valid;
  logic [WORD_SIZE-1:0]  tx_data;
  logic                  tx_valid;

  modport slave (
    input  SS_n,
    input  MOSI,
    input  tx_data,
    input  tx_valid,
    output MISO,
    output rx_data,
    output rx_valid
  );

  modport master (
    output SS_n,
    output MOSI,
    output tx_data,
    output tx_valid,
    input  MISO,
    input  rx_data,
    input  rx_valid
  );

endinterface

// File: rtl/spi_shift_reg.sv
// ---------------------------------------------------------------------------
// spi_shift_reg
// Serial-in/parallel-out receive register with a saturating bit counter,
// plus a parallel-in/serial-out transmit register (MSB first).
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   clr          : synchronous clear of both halves (frame abort / idle)
//   rx_shift_en  : shift rx_bit in on this edge (ignored once full)
//   rx_bit       : serial input
//   rx_word      : receive shift register contents
//   rx_done      : IN_W bits have been captured
//   tx_load      : load tx_word; first bit appears on the following edge
//   tx_word      : parallel transmit data
//   tx_last      : the current edge shifts out the final bit
//   sout         : registered serial output, 0 when not transmitting
// ---------------------------------------------------------------------------
module spi_shift_reg #(
  parameter int IN_W  = 10,
  parameter int OUT_W = 8,
  parameter int CNT_W = 4   // 2**CNT_W must exceed IN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             rx_shift_en,
  input  logic             rx_bit,
  output logic [IN_W-1:0]  rx_word,
  output logic             rx_done,
  input  logic             tx_load,
  input  logic [OUT_W-1:0] tx_word,
  output logic             tx_last,
  output logic             sout
);

  localparam int               TX_CNT_W = $clog2(OUT_W + 1);
  localparam logic [CNT_W-1:0] RX_FULL  = CNT_W'(IN_W);

  logic [IN_W-1:0]     rx_sh_reg;
  logic [IN_W-1:0]     rx_sh_next;
  logic [CNT_W-1:0]    rx_cnt_reg;
  logic [OUT_W-1:0]    tx_sh_reg;
  logic [OUT_W-1:0]    tx_sh_next;
  logic [TX_CNT_W-1:0] tx_cnt_reg;
  logic                sout_reg;

  genvar gi;

  // Receive: shift towards the MSB, new bit enters at bit 0.
  assign rx_sh_next[0] = rx_bit;
  for (gi = 1; gi < IN_W; gi++) begin : g_rx_shift
    assign rx_sh_next[gi] = rx_sh_reg[gi-1];
  end

  // Transmit: MSB leaves first, zeros fill from the bottom.
  assign tx_sh_next[0] = 1'b0;
  for (gi = 1; gi < OUT_W; gi++) begin : g_tx_shift
    assign tx_sh_next[gi] = tx_sh_reg[gi-1];
  end

  assign rx_done = (rx_cnt_reg == RX_FULL);
  assign tx_last = (tx_cnt_reg == TX_CNT_W'(1));
  assign rx_word = rx_sh_reg;
  assign sout    = sout_reg;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      rx_sh_reg  <= '0;
      rx_cnt_reg <= '0;
      tx_sh_reg  <= '0;
      tx_cnt_reg <= '0;
      sout_reg   <= 1'b0;
    end else begin
      // Counter stops at IN_W so a long-held select never wraps a frame.
      if (rx_shift_en && !rx_done) begin
        rx_sh_reg  <= rx_sh_next;
        rx_cnt_reg <= rx_cnt_reg + CNT_W'(1);
      end

      if (tx_load) begin
        tx_sh_reg  <= tx_word;
        tx_cnt_reg <= TX_CNT_W'(OUT_W);
        sout_reg   <= 1'b0;
      end else if (tx_cnt_reg != '0) begin
        sout_reg   <= tx_sh_reg[OUT_W-1];
        tx_sh_reg  <= tx_sh_next;
        tx_cnt_reg <= tx_cnt_reg - TX_CNT_W'(1);
      end else begin
        sout_reg   <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/spi_slave_frontend.sv
// ---------------------------------------------------------------------------
// spi_slave_frontend
// SPI slave front end feeding the single-port command RAM. Deserialises
// INPUT_SIZE-bit MOSI frames into rx_data with a one-cycle rx_valid strobe;
// for read-data frames it waits for tx_valid, captures tx_data and shifts
// it out on MISO, MSB first.
// Ports:
//   clk    : SPI serial clock, all logic on posedge
//   rst_n  : synchronous active-low reset (dominates SS_n)
//   bus    : spi_slave_frontend_if.slave (SS_n, MOSI, MISO, rx_data,
//            rx_valid, tx_data, tx_valid)
// ---------------------------------------------------------------------------
module spi_slave_frontend
  import spi_pkg::*;
#(
  parameter int INPUT_SIZE = SPI_INPUT_SIZE,
  parameter int WORD_SIZE  = SPI_WORD_SIZE,
  parameter int CNT_W      = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  spi_slave_frontend_if.slave bus
);

  state_t state_reg;
  state_t state_next;

  logic [INPUT_SIZE-1:0] rx_data_reg;
  logic                  rx_valid_reg;
  logic                  rd_addr_seen_reg;
  logic                  delivered_reg;   // this frame's rx_valid already issued
  logic                  tx_started_reg;  // read data already captured this frame

  logic                  clr;
  logic                  rx_shift_en;
  logic                  deliver;
  logic                  tx_load;
  logic [INPUT_SIZE-1:0] rx_word;
  logic                  rx_done;
  logic                  tx_last;
  logic                  sout;

  spi_shift_reg #(
    .IN_W  (INPUT_SIZE),
    .OUT_W (WORD_SIZE),
    .CNT_W (CNT_W)
  ) u_shift (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .rx_shift_en (rx_shift_en),
    .rx_bit      (bus.MOSI),
    .rx_word     (rx_word),
    .rx_done     (rx_done),
    .tx_load     (tx_load),
    .tx_word     (bus.tx_data),
    .tx_last     (tx_last),
    .sout        (sout)
  );

  always_comb begin
    state_next  = state_reg;
    clr         = 1'b0;
    rx_shift_en = 1'b0;
    deliver     = 1'b0;
    tx_load     = 1'b0;

    if (bus.SS_n) begin
      // Deselect aborts everything, partial frames are dropped.
      state_next = IDLE;
      clr        = 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          // The select edge itself carries no data bit.
          clr        = 1'b1;
          state_next = CHK_CMD;
        end
        CHK_CMD: begin
          // Bit 9 is captured here and also picks the path.
          rx_shift_en = 1'b1;
          if (!bus.MOSI)            state_next = WRITE;
          else if (rd_addr_seen_reg) state_next = READ_DATA;
          else                       state_next = READ_ADD;
        end
        WRITE, READ_ADD: begin
          rx_shift_en = !rx_done;
          deliver     = rx_done && !delivered_reg;
        end
        READ_DATA: begin
          rx_shift_en = !rx_done;
          deliver     = rx_done && !delivered_reg;
          // Only a tx_valid seen after the strobe went out is accepted.
          tx_load     = delivered_reg && !tx_started_reg && bus.tx_valid;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      rx_data_reg      <= '0;
      rx_valid_reg     <= 1'b0;
      rd_addr_seen_reg <= 1'b0;
      delivered_reg    <= 1'b0;
      tx_started_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rx_valid_reg <= deliver;
      if (deliver) begin
        rx_data_reg <= rx_word;
      end

      if (clr) begin
        delivered_reg  <= 1'b0;
        tx_started_reg <= 1'b0;
      end else begin
        if (deliver) delivered_reg  <= 1'b1;
        if (tx_load) tx_started_reg <= 1'b1;
      end

      // An aborted transfer leaves the flag alone.
      if (deliver && (state_reg == READ_ADD)) begin
        rd_addr_seen_reg <= 1'b1;
      end else if (tx_last && !clr) begin
        rd_addr_seen_reg <= 1'b0;
      end
    end
  end

  assign bus.rx_data  = rx_data_reg;
  assign bus.rx_valid = rx_valid_reg;
  assign bus.MISO     = sout;

endmodule
